// File: rtl/mem_result_packer.sv
// rtl/mem_result_packer.sv - collects per-read mem entries and streams them as header + packed body beats
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   stall                 freezes all state, storage writes and outputs
//   start, batch_size     begin a batch of batch_size reads (accepted in IDLE/FINISH)
//   wr_*                  mem-entry write port (read number, slot address, 256-bit entry)
//   size_*                per-read completion report carrying the entry count
//   ret_*                 per-read return code
//   out_valid/out_ready   output stream handshake; out_data is one LINE_W beat, out_last ends a read
//   out_finish            high while the finished batch is parked in FINISH
//   busy                  high while a batch is being collected or streamed
//   drop_err              sticky flag for rejected writes
module mem_result_packer #(
  parameter int READ_NUM_WIDTH = 9,
  parameter int SLOTS          = 30,
  parameter int LANES          = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall,
  input  logic                          start,
  input  logic [READ_NUM_WIDTH:0]       batch_size,
  input  logic                          wr_valid,
  input  logic [READ_NUM_WIDTH-1:0]     wr_read_num,
  input  logic [6:0]                    wr_addr,
  input  logic [255:0]                  wr_data,
  input  logic                          size_valid,
  input  logic [READ_NUM_WIDTH-1:0]     size_read_num,
  input  logic [6:0]                    mem_size,
  input  logic                          ret_valid,
  input  logic [READ_NUM_WIDTH-1:0]     ret_read_num,
  input  logic [6:0]                    ret,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [256*LANES-1:0]          out_data,
  output logic                          out_last,
  output logic                          out_finish,
  output logic                          busy,
  output logic                          drop_err
);

  localparam int MAX_READ = 2**READ_NUM_WIDTH;
  localparam int LINE_W   = 256*LANES;
  localparam int DEPTH    = MAX_READ*SLOTS;
  localparam int ADDR_W   = $clog2(DEPTH);
  localparam int CNT_W    = READ_NUM_WIDTH+1;
  localparam int ENTRY_W  = 113;
  localparam logic [6:0] SLOTS7 = 7'(SLOTS);
  localparam logic [7:0] LANES8 = 8'(LANES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_HEADER,
    S_BODY,
    S_NEXT,
    S_FINISH
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]          batch_q;
  logic [CNT_W-1:0]          done_count;
  logic [READ_NUM_WIDTH-1:0] ptr;
  logic [7:0]                base;

  logic [ENTRY_W-1:0] mem      [DEPTH];
  logic [6:0]         size_tab [MAX_READ];
  logic [6:0]         ret_tab  [MAX_READ];
  logic [ENTRY_W-1:0] rd_q     [LANES];
  logic [ADDR_W-1:0]  rd_addr  [LANES];
  logic [LANES-1:0]   lane_ok;

  // Stage 1 holds the beat whose body lanes are in rd_q; stage 2 is the output register.
  logic                      s1_valid;
  logic                      s1_hdr;
  logic                      s1_last;
  logic [LANES-1:0]          s1_mask;
  logic [READ_NUM_WIDTH-1:0] s1_ptr;
  logic [6:0]                s1_size;
  logic [6:0]                s1_ret;
  logic [LINE_W-1:0]         s1_line;

  logic               fire, out_free, s1_adv, issue_ok, pipe_empty;
  logic               issue_hdr, issue_body, ptr_inc, body_last;
  logic [6:0]         cur_size, cur_ret;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ADDR_W-1:0]  wr_idx;
  logic               wr_ok;
  logic               unused_bits;

  assign wr_entry = {wr_data[230:224], wr_data[198:192], wr_data[160:128],
                     wr_data[96:64], wr_data[32:0]};
  assign unused_bits = ^{wr_data[255:231], wr_data[223:199], wr_data[191:161],
                         wr_data[127:97], wr_data[63:33]};
  assign wr_idx = ADDR_W'(wr_read_num) * ADDR_W'(SLOTS) + ADDR_W'(wr_addr);
  assign wr_ok  = (state == S_COLLECT) && wr_valid && (wr_addr < SLOTS7);

  function automatic logic [255:0] unpack(input logic [ENTRY_W-1:0] e);
    logic [255:0] l;
    l = '0;
    l[230:224] = e[112:106];
    l[198:192] = e[105:99];
    l[160:128] = e[98:66];
    l[96:64]   = e[65:33];
    l[32:0]    = e[32:0];
    return l;
  endfunction

  assign cur_size = size_tab[ptr];
  assign cur_ret  = ret_tab[ptr];

  // The ready chain runs combinationally back to the issue point so that a
  // continuously ready sink sees one beat per cycle.
  assign fire       = out_valid & out_ready & ~stall;
  assign out_free   = ~out_valid | fire;
  assign s1_adv     = s1_valid & out_free;
  assign issue_ok   = ~s1_valid | out_free;
  assign pipe_empty = ~s1_valid & ~out_valid;
  assign body_last  = (base + LANES8) >= {1'b0, cur_size};

  always_comb begin
    lane_ok = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_ok[k] = (base + 8'(k)) < {1'b0, cur_size};
      // Lanes past mem_size are masked; point them at slot 0 to stay in range.
      rd_addr[k] = ADDR_W'(ptr) * ADDR_W'(SLOTS) + (lane_ok[k] ? ADDR_W'(base + 8'(k)) : '0);
    end
  end

  always_comb begin
    s1_line = '0;
    if (s1_hdr) begin
      s1_line[READ_NUM_WIDTH-1:0] = s1_ptr;
      s1_line[70:64]              = s1_size;
      s1_line[134:128]            = s1_ret;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (s1_mask[k]) s1_line[256*k +: 256] = unpack(rd_q[k]);
      end
    end
  end

  always_comb begin
    state_next = state;
    issue_hdr  = 1'b0;
    issue_body = 1'b0;
    ptr_inc    = 1'b0;
    case (state)
      S_IDLE, S_FINISH: begin
        if (start) state_next = (batch_size == '0) ? S_FINISH : S_COLLECT;
      end
      S_COLLECT: begin
        if (done_count == batch_q) state_next = S_HEADER;
      end
      S_HEADER: begin
        if (issue_ok) begin
          issue_hdr  = 1'b1;
          state_next = (cur_size == '0) ? S_NEXT : S_BODY;
        end
      end
      S_BODY: begin
        if (issue_ok) begin
          issue_body = 1'b1;
          if (body_last) state_next = S_NEXT;
        end
      end
      S_NEXT: begin
        // The final read waits for the pipeline to drain so FINISH never shows out_valid.
        if (({1'b0, ptr} + CNT_W'(1)) == batch_q) begin
          if (pipe_empty) state_next = S_FINISH;
        end else begin
          ptr_inc    = 1'b1;
          state_next = S_HEADER;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      batch_q    <= '0;
      done_count <= '0;
      ptr        <= '0;
      base       <= '0;
      s1_valid   <= 1'b0;
      s1_hdr     <= 1'b0;
      s1_last    <= 1'b0;
      s1_mask    <= '0;
      s1_ptr     <= '0;
      s1_size    <= '0;
      s1_ret     <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
      drop_err   <= 1'b0;
    end else if (!stall) begin
      state <= state_next;
      if ((state == S_IDLE || state == S_FINISH) && start) begin
        batch_q    <= batch_size;
        done_count <= '0;
        ptr        <= '0;
      end
      if (state == S_COLLECT && size_valid) done_count <= done_count + CNT_W'(1);
      if (wr_valid && !wr_ok) drop_err <= 1'b1;
      if (issue_hdr)  base <= '0;
      if (issue_body) base <= base + LANES8;
      if (ptr_inc)    ptr  <= ptr + 1'b1;

      if (issue_hdr || issue_body) begin
        s1_valid <= 1'b1;
        s1_hdr   <= issue_hdr;
        s1_last  <= issue_hdr ? (cur_size == '0) : body_last;
        s1_mask  <= lane_ok;
        s1_ptr   <= ptr;
        s1_size  <= cur_size;
        s1_ret   <= cur_ret;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end

      if (s1_adv) begin
        out_valid <= 1'b1;
        out_data  <= s1_line;
        out_last  <= s1_last;
      end else if (fire) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  // Storage is not reset; entries are always written before they are read.
  always_ff @(posedge clk) begin
    if (!reset && !stall) begin
      if (wr_ok) mem[wr_idx] <= wr_entry;
      if (state == S_COLLECT && size_valid)
        size_tab[size_read_num] <= (mem_size > SLOTS7) ? SLOTS7 : mem_size;
      if (state == S_COLLECT && ret_valid) ret_tab[ret_read_num] <= ret;
      if (issue_body) begin
        for (int k = 0; k < LANES; k++) rd_q[k] <= mem[rd_addr[k]];
      end
    end
  end

  assign busy       = (state == S_COLLECT) || (state == S_HEADER) ||
                      (state == S_BODY) || (state == S_NEXT);
  assign out_finish = (state == S_FINISH);

endmodule

// File: tb/tb_mem_result_packer.sv
// tb/tb_mem_result_packer.sv - scoreboard bench for mem_result_packer
module tb_mem_result_packer;

  localparam int RNW   = 9;
  localparam int SLOTS = 30;
  localparam int LANES = 2;
  localparam int LW    = 256*LANES;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           stall;
  logic           start = 1'b0;
  logic [RNW:0]   batch_size = '0;
  logic           wr_valid = 1'b0;
  logic [RNW-1:0] wr_read_num = '0;
  logic [6:0]     wr_addr = '0;
  logic [255:0]   wr_data = '0;
  logic           size_valid = 1'b0;
  logic [RNW-1:0] size_read_num = '0;
  logic [6:0]     mem_size = '0;
  logic           ret_valid = 1'b0;
  logic [RNW-1:0] ret_read_num = '0;
  logic [6:0]     ret = '0;
  logic           out_valid;
  logic           out_ready;
  logic [LW-1:0]  out_data;
  logic           out_last;
  logic           out_finish;
  logic           busy;
  logic           drop_err;

  mem_result_packer #(.READ_NUM_WIDTH(RNW), .SLOTS(SLOTS), .LANES(LANES)) dut (
    .clk(clk), .reset(reset), .stall(stall), .start(start), .batch_size(batch_size),
    .wr_valid(wr_valid), .wr_read_num(wr_read_num), .wr_addr(wr_addr), .wr_data(wr_data),
    .size_valid(size_valid), .size_read_num(size_read_num), .mem_size(mem_size),
    .ret_valid(ret_valid), .ret_read_num(ret_read_num), .ret(ret),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_finish(out_finish), .busy(busy), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails = 0;
  int beats_seen = 0;
  int mode = 0;
  logic man_ready = 1'b1;
  logic man_stall = 1'b0;

  logic [LW:0]   exp_q[$];
  logic [255:0]  mdl [0:7][0:SLOTS-1];
  logic [255:0]  fmask;
  int            b_size [8];
  int            b_ret  [8];

  task automatic chk(input string name, input logic [LW+1:0] act, input logic [LW+1:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  function automatic logic [255:0] field_mask();
    logic [255:0] m;
    m = '0;
    for (int i = 0; i < 256; i++)
      if (i <= 32 || (i >= 64 && i <= 96) || (i >= 128 && i <= 160) ||
          (i >= 192 && i <= 198) || (i >= 224 && i <= 230)) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Ready/stall driver: 0 = always ready, 1 = toggle, 2 = random, 3 = manual.
  initial begin
    out_ready = 1'b1;
    stall = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (mode)
        0: begin out_ready = 1'b1; stall = 1'b0; end
        1: begin out_ready = ~out_ready; stall = 1'b0; end
        2: begin out_ready = ($urandom_range(0, 3) != 0); stall = ($urandom_range(0, 4) == 0); end
        default: begin out_ready = man_ready; stall = man_stall; end
      endcase
    end
  end

  // Monitor: pops the scoreboard on every transfer and checks hold-stability.
  logic        held_v = 1'b0;
  logic [LW:0] held;
  always @(negedge clk) begin
    if (reset) begin
      held_v = 1'b0;
    end else begin
      if (held_v) chk("hold", {out_valid, out_last, out_data}, {1'b1, held});
      if (out_valid && out_ready && !stall) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", {1'b0, out_last, out_data}, '0);
        end else begin
          chk("beat", {1'b0, out_last, out_data}, {1'b0, exp_q.pop_front()});
        end
        beats_seen++;
      end
      held_v = out_valid && (!out_ready || stall);
      held = {out_last, out_data};
    end
  end

  task automatic push_expected(input int bs);
    logic [LW-1:0] line;
    for (int r = 0; r < bs; r++) begin
      int n;
      int nb;
      n = (b_size[r] > SLOTS) ? SLOTS : b_size[r];
      nb = (n + LANES - 1) / LANES;
      line = '0;
      line[RNW-1:0] = r[RNW-1:0];
      line[70:64] = n[6:0];
      line[134:128] = b_ret[r][6:0];
      exp_q.push_back({n == 0, line});
      for (int j = 0; j < nb; j++) begin
        line = '0;
        for (int k = 0; k < LANES; k++)
          if (j*LANES + k < n) line[256*k +: 256] = mdl[r][j*LANES + k];
        exp_q.push_back({j == nb - 1, line});
      end
    end
  endtask

  task automatic do_collect(input int bs, input bit bad_wr);
    @(posedge clk); #1;
    start = 1'b1;
    batch_size = (RNW+1)'(bs);
    @(posedge clk); #1;
    start = 1'b0;
    for (int r = 0; r < bs; r++) begin
      int n;
      n = (b_size[r] > SLOTS) ? SLOTS : b_size[r];
      for (int s = 0; s < n; s++) begin
        wr_valid = 1'b1; wr_read_num = RNW'(r); wr_addr = 7'(s); wr_data = rand256();
        mdl[r][s] = wr_data & fmask;
        @(posedge clk); #1;
      end
      wr_valid = 1'b0;
      if (bad_wr && r == bs - 1) begin
        // Slot 30 of read 0 aliases slot 0 of read 1 if the range check were missing.
        wr_valid = 1'b1; wr_read_num = '0; wr_addr = 7'(SLOTS); wr_data = rand256();
        @(posedge clk); #1;
        wr_valid = 1'b0;
      end
      size_valid = 1'b1; size_read_num = RNW'(r); mem_size = 7'(b_size[r]);
      ret_valid = 1'b1; ret_read_num = RNW'(r); ret = 7'(b_ret[r]);
      @(posedge clk); #1;
      size_valid = 1'b0; ret_valid = 1'b0;
    end
    push_expected(bs);
  endtask

  task automatic wait_finish(input string name);
    int c;
    c = 0;
    while (!out_finish && c < 5000) begin @(posedge clk); c++; end
    @(negedge clk);
    chk_i({name, "_finish"}, int'(out_finish), 1);
    chk_i({name, "_drained"}, exp_q.size(), 0);
    chk_i({name, "_idle_valid"}, int'(out_valid), 0);
    chk_i({name, "_busy"}, int'(busy), 0);
    exp_q.delete();
  endtask

  task automatic wait_beats(input int n);
    int c;
    c = 0;
    while (beats_seen < n && c < 2000) begin @(posedge clk); c++; end
    if (beats_seen < n) chk_i("wait_beats_timeout", beats_seen, n);
  endtask

  initial begin
    int b0;
    int b1;
    fmask = field_mask();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_i("rst_valid", int'(out_valid), 0);
    chk_i("rst_last", int'(out_last), 0);
    chk("rst_data", {2'b0, out_data}, '0);
    chk_i("rst_finish", int'(out_finish), 0);
    chk_i("rst_busy", int'(busy), 0);
    chk_i("rst_drop", int'(drop_err), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Empty batch goes straight to FINISH.
    start = 1'b1; batch_size = '0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk_i("bs0_finish", int'(out_finish), 1);
    chk_i("bs0_busy", int'(busy), 0);

    // Three entries, ret 5.
    mode = 0;
    b_size[0] = 3; b_ret[0] = 5;
    do_collect(1, 1'b0);
    wait_finish("basic");

    // Second read reports zero entries.
    b_size[0] = 5; b_ret[0] = 17; b_size[1] = 0; b_ret[1] = 99;
    b0 = beats_seen;
    do_collect(2, 1'b0);
    wait_finish("empty_read");
    chk_i("empty_read_beats", beats_seen - b0, 5);

    // Ready toggling every cycle.
    mode = 1;
    b_size[0] = 9; b_ret[0] = 3; b_size[1] = 12; b_ret[1] = 44;
    do_collect(2, 1'b0);
    wait_finish("toggle");

    // Five-cycle stall mid-body.
    mode = 3; man_ready = 1'b1; man_stall = 1'b0;
    b_size[0] = 16; b_ret[0] = 8;
    b0 = beats_seen;
    do_collect(1, 1'b0);
    wait_beats(b0 + 3);
    man_stall = 1'b1;
    @(posedge clk); #2;
    b0 = beats_seen;
    repeat (5) @(posedge clk);
    #2;
    b1 = beats_seen;
    man_stall = 1'b0;
    chk_i("stall_no_xfer", b1, b0);
    wait_finish("stall");

    // Out-of-range write and a write while streaming are both dropped.
    chk_i("drop_before", int'(drop_err), 0);
    man_ready = 1'b0;
    b_size[0] = 4; b_ret[0] = 1; b_size[1] = 4; b_ret[1] = 2;
    do_collect(2, 1'b1);
    b0 = 0;
    while (!out_valid && b0 < 100) begin @(posedge clk); #1; b0++; end
    chk_i("drop_hdr_seen", int'(out_valid), 1);
    wr_valid = 1'b1; wr_read_num = RNW'(1); wr_addr = '0; wr_data = rand256();
    @(posedge clk); #1;
    wr_valid = 1'b0;
    @(negedge clk);
    chk_i("drop_err", int'(drop_err), 1);
    man_ready = 1'b1;
    wait_finish("drop");

    // Reset mid-body, then a fresh batch.
    b_size[0] = 20; b_ret[0] = 6;
    b0 = beats_seen;
    do_collect(1, 1'b0);
    wait_beats(b0 + 3);
    man_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_i("mid_rst_valid", int'(out_valid), 0);
    chk_i("mid_rst_last", int'(out_last), 0);
    chk("mid_rst_data", {2'b0, out_data}, '0);
    chk_i("mid_rst_busy", int'(busy), 0);
    chk_i("mid_rst_finish", int'(out_finish), 0);
    chk_i("mid_rst_drop", int'(drop_err), 0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    mode = 0;
    b_size[0] = 7; b_ret[0] = 77;
    do_collect(1, 1'b0);
    wait_finish("after_rst");

    // Randomized batches with random ready and stall.
    for (int t = 0; t < 8; t++) begin
      int bs;
      bs = $urandom_range(1, 4);
      for (int r = 0; r < bs; r++) begin
        b_size[r] = $urandom_range(0, 33);
        b_ret[r] = $urandom_range(0, 127);
      end
      mode = 0;
      do_collect(bs, 1'b0);
      mode = 2;
      wait_finish("random");
    end

    mode = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_result_packer.md
MEM_RESULT_PACKER -- requirements
Module: mem_result_packer

Interface
REQ-001: The module SHALL have parameter READ_NUM_WIDTH, default 9, meaning read-index width (MAX_READ = 2**READ_NUM_WIDTH).
REQ-002: The module SHALL have parameter SLOTS, default 30, meaning mem entries stored per read.
REQ-003: The module SHALL have parameter LANES, default 2, meaning 256-bit entry lanes per output line (LINE_W = 256*LANES).
REQ-004: The module SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005: The module SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-006: The module SHALL have port stall, input, 1 bit; when high, all state, storage writes and outputs are frozen.
REQ-007: The module SHALL have port start, input, 1 bit, a one-cycle pulse that begins a batch (IDLE/FINISH only).
REQ-008: The module SHALL have port batch_size, input, READ_NUM_WIDTH+1 bits, number of reads; sampled on start.
REQ-009: The module SHALL have ports wr_valid (input, 1), wr_read_num (input, READ_NUM_WIDTH), wr_addr (input, 7) and wr_data (input, 256): the mem-entry write port.
REQ-010: The module SHALL have ports size_valid (input, 1), size_read_num (input, READ_NUM_WIDTH) and mem_size (input, 7): the per-read completion report.
REQ-011: The module SHALL have ports ret_valid (input, 1), ret_read_num (input, READ_NUM_WIDTH) and ret (input, 7): the per-read return code.
REQ-012: The module SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, LINE_W), out_last (output, 1): the output stream.
REQ-013: The module SHALL have ports out_finish (output, 1), busy (output, 1) and drop_err (output, 1, sticky).

Function
REQ-014: The entry SHALL pack as 113 bits from wr_data[230:224],[198:192],[160:128],[96:64],[32:0]; lane k of out_data SHALL restore those bits at offset 256*k, all other bits zero.
REQ-015: Storage SHALL be MAX_READ*SLOTS entries at address read_num*SLOTS+addr, with 1-cycle registered read latency.
REQ-016: The FSM SHALL have states IDLE, COLLECT, HEADER, BODY, NEXT and FINISH.
REQ-017: IDLE/FINISH + start SHALL go to COLLECT, latching batch_size and clearing done_count, read pointer and out_finish.
REQ-018: start with batch_size==0 SHALL go directly to FINISH.
REQ-019: COLLECT SHALL accept writes; each size_valid SHALL store min(mem_size,SLOTS) and increment done_count; ret_valid SHALL store ret, both accepted in the same cycle.
REQ-020: wr_valid with wr_addr>=SLOTS, or in any state other than COLLECT, SHALL be dropped and set drop_err.
REQ-021: COLLECT SHALL go to HEADER on the cycle after done_count==batch_size.
REQ-022: HEADER SHALL present one beat: [READ_NUM_WIDTH-1:0]=read pointer, [70:64]=mem_size, [134:128]=ret, all else zero.
REQ-023: BODY SHALL present ceil(mem_size/LANES) beats; beat j lane k SHALL carry entry j*LANES+k, and lanes >= mem_size SHALL be zero.
REQ-024: out_last SHALL be high on the final beat of each read (the header when mem_size==0).
REQ-025: A beat transfers only when out_valid & out_ready & !stall; out_data/out_last SHALL hold stable while out_valid & !out_ready.
REQ-026: Back-to-back beats SHALL be sustained at one per cycle when out_ready stays high; prefetch/skid as required.
REQ-027: NEXT SHALL increment the read pointer and go to HEADER, or to FINISH if pointer+1==batch_size.
REQ-028: FINISH SHALL hold out_finish=1, out_valid=0 until start or reset.
REQ-029: busy SHALL be 1 in COLLECT, HEADER, BODY and NEXT.

Reset
REQ-030: On reset, state SHALL be IDLE and out_valid, out_last, out_finish, busy, drop_err and done_count SHALL be 0; out_data SHALL be 0.
REQ-031: reset SHALL override stall and abort any batch mid-stream; storage contents need not be cleared.

Verification
REQ-032: batch_size=1, read 0 gets 3 writes (addr 0..2), mem_size=3, ret=5 -> header {0,3,5}, beat(e0,e1), beat(e2,0) with out_last, then out_finish=1.
REQ-033: batch_size=2, read 1 mem_size=0 -> read 1 emits header only with out_last=1; total beats = 1 + (read 0 beats).
REQ-034: out_ready toggled 1/0 each cycle during BODY -> no beat lost/duplicated, data stable while not ready.
REQ-035: stall for 5 cycles mid-BODY with out_ready=1 -> no transfer during stall, stream resumes identically.
REQ-036: wr_valid with wr_addr=30, then a write during HEADER -> both dropped, drop_err=1, stream unchanged.
REQ-037: reset asserted mid-BODY, then new start with batch_size=1 -> IDLE, outputs 0, second batch emits correctly.
